pack_sequencer: RTL
===================

Name: pack_sequencer

Overview:
Controller that sequences the PackingUnit to assemble one full 128-bit AES state from successive ALU beats. Per beat, the PackingUnit returns four 16-bit half-rows (64 bits). This block drives the PackingUnit mode, collects NUM_BEATS beats into a state register, and hands the packed state to the next pipeline stage over a valid/ready handshake. It sits between the vector ALU/PackingUnit pair and the state writeback stage.

Parameters:
HALF_W, 16, width of one half-row from the PackingUnit
NUM_ROWS, 4, half-rows per beat / rows in the state
NUM_BEATS, 2, beats per state; row width = HALF_W*NUM_BEATS; state width = NUM_ROWS*HALF_W*NUM_BEATS (128 at defaults)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  begin collecting a new state
mc_mode  in  1  MixColumns mode request, sampled only when start is accepted
abort  in  1  synchronous abort of the current collection
pack_mc_mode  out  1  MCMode drive to PackingUnit
beat_valid  in  1  half_row0..3 carry a valid beat
beat_ready  out  1  sequencer accepts a beat this cycle
half_row0..half_row3  in  HALF_W each  PackingUnit outputs
beat_idx  out  $clog2(NUM_BEATS)  index of the next beat expected
busy  out  1  FSM not IDLE
state_out  out  NUM_ROWS*HALF_W*NUM_BEATS  packed state
state_valid  out  1  state_out holds a complete state
state_ready  in  1  downstream accepts state_out
start_err  out  1  one-cycle pulse: start asserted while it could not be accepted

Behaviour:
- Reset (async, rst=1): FSM=IDLE; beat_idx=0; mode register=0; state register=0; pack_mc_mode=0, beat_ready=0, busy=0, state_valid=0, start_err=0. Releasing rst mid-collection leaves the block in IDLE with no partial data retained.
- FSM states: IDLE, COLLECT, DONE.
- IDLE: start=1 -> latch mc_mode into mode register, clear beat_idx, go COLLECT. State register is not cleared; it is fully overwritten by the beats.
- COLLECT: beat_ready=1, busy=1, pack_mc_mode = latched mode. A beat is accepted on beat_valid & beat_ready. For accepted beat b, row r field [(NUM_BEATS-b)*HALF_W-1 -: HALF_W] <= half_row_r, so beat 0 fills the MSBs of each row. beat_idx increments per accepted beat. Accepting beat NUM_BEATS-1 -> go DONE; beat_idx wraps to 0.
- Packing order: state_out = {row0,row1,row2,row3}, with row0 in the MSBs.
- DONE: state_valid=1, beat_ready=0, pack_mc_mode still holds the latched mode. state_out is stable while state_valid & !state_ready. On state_ready=1: with start=1 in the same cycle, latch the new mc_mode and go directly to COLLECT (back-to-back, no idle bubble); otherwise go IDLE.
- Latency: state_valid rises the cycle after the last beat is accepted. Minimum state period is NUM_BEATS+1 cycles.
- start while in COLLECT, or in DONE without state_ready: ignored, start_err pulses for 1 cycle.
- abort=1 in COLLECT or DONE: go IDLE next cycle, drop state_valid, clear beat_idx. abort has priority over beat acceptance, state_ready and start in the same cycle. abort in IDLE has no effect and blocks start in that cycle.
- beat_valid outside COLLECT: ignored, no error.
- pack_mc_mode=0 in IDLE.

Test Plan:
- Reset, then start with mc_mode=1. Beat0 half_rows 0102,0304,0506,0708; beat1 090a,0b0c,0d0e,0f10 -> state_out=0102090a_03040b0c_05060d0e_07080f10 and state_valid=1 one cycle after beat1. pack_mc_mode=1 throughout COLLECT/DONE.
- Same beats with mc_mode=0, and state_ready held 0 for 3 cycles -> state_out stable and state_valid held. Accepted on the 4th cycle, then FSM IDLE with pack_mc_mode=0.
- Back-to-back: state_ready=1 and start=1 (mc_mode=0) in DONE -> busy stays 1, COLLECT next cycle, new beat0 accepted immediately, pack_mc_mode switches to 0.
- Beats with gaps (beat_valid toggling 1,0,0,1) -> only 2 beats counted, beat_idx 0->1->0, correct state assembled.
- start during COLLECT -> start_err single-cycle pulse, beat_idx unchanged. abort after beat0 -> IDLE, state_valid never asserted.
- rst asserted asynchronously mid-COLLECT (between clock edges) -> all outputs 0 immediately. After release, the next start collects a fresh state correctly.

Source files
------------

// File: rtl/pack_sequencer.sv
// pack_sequencer: drives the PackingUnit mode, gathers NUM_BEATS beats of
// NUM_ROWS half-rows into one packed state, and presents that state to the
// writeback stage over a valid/ready handshake.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for start; PackingUnit mode forced to 0
// S_COLLECT  | accepting beats; beat_idx selects the row field to fill
// S_DONE     | state_out complete and held until state_ready (or abort)
module pack_sequencer #(
  parameter int HALF_W    = 16,
  parameter int NUM_ROWS  = 4,
  parameter int NUM_BEATS = 2,
  localparam int IDX_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1,
  localparam int ROW_W    = HALF_W * NUM_BEATS,
  localparam int STATE_W  = NUM_ROWS * ROW_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mc_mode,
  input  logic               abort,
  output logic               pack_mc_mode,
  input  logic               beat_valid,
  output logic               beat_ready,
  input  logic [HALF_W-1:0]  half_row0,
  input  logic [HALF_W-1:0]  half_row1,
  input  logic [HALF_W-1:0]  half_row2,
  input  logic [HALF_W-1:0]  half_row3,
  output logic [IDX_W-1:0]   beat_idx,
  output logic               busy,
  output logic [STATE_W-1:0] state_out,
  output logic               state_valid,
  input  logic               state_ready,
  output logic               start_err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]         fsm;
  logic               mode_q;
  logic [STATE_W-1:0] state_q;
  logic [HALF_W-1:0]  half_rows [4];
  logic               beat_accept;
  logic               last_beat;

  assign half_rows[0] = half_row0;
  assign half_rows[1] = half_row1;
  assign half_rows[2] = half_row2;
  assign half_rows[3] = half_row3;

  // abort wins over a beat arriving in the same cycle
  assign beat_accept = (fsm == S_COLLECT) && beat_valid && !abort;
  assign last_beat   = (beat_idx == IDX_W'(NUM_BEATS - 1));

  assign busy         = (fsm != S_IDLE);
  assign beat_ready   = (fsm == S_COLLECT);
  assign state_valid  = (fsm == S_DONE);
  assign pack_mc_mode = (fsm != S_IDLE) && mode_q;
  assign state_out    = state_q;

  // Control FSM, beat counter, latched mode and start-error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= S_IDLE;
      beat_idx  <= '0;
      mode_q    <= 1'b0;
      start_err <= 1'b0;
    end else begin
      start_err <= start && !abort &&
                   ((fsm == S_COLLECT) || ((fsm == S_DONE) && !state_ready));
      case (fsm)
        S_IDLE: begin
          if (start && !abort) begin
            mode_q   <= mc_mode;
            beat_idx <= '0;
            fsm      <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (abort) begin
            beat_idx <= '0;
            fsm      <= S_IDLE;
          end else if (beat_valid) begin
            if (last_beat) begin
              beat_idx <= '0;
              fsm      <= S_DONE;
            end else begin
              beat_idx <= beat_idx + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (abort) begin
            beat_idx <= '0;
            fsm      <= S_IDLE;
          end else if (state_ready) begin
            if (start) begin
              // back-to-back: next collection starts without an idle bubble
              mode_q   <= mc_mode;
              beat_idx <= '0;
              fsm      <= S_COLLECT;
            end else begin
              fsm <= S_IDLE;
            end
          end
        end
        default: begin
          beat_idx <= '0;
          fsm      <= S_IDLE;
        end
      endcase
    end
  end

  // State register: beat b lands in each row's field counted from the MSB end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
    end else if (beat_accept) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        state_q[(NUM_ROWS - 1 - r) * ROW_W + (NUM_BEATS - int'(beat_idx)) * HALF_W - 1 -: HALF_W]
          <= half_rows[r];
      end
    end
  end

endmodule
